i2c_txn_arbiter: RTL

//   Shares one i2c_master instance between N_REQ requesters (sensor pollers, config loaders).

---
 rtl/i2c_txn_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_arbiter
// Brief    : Round-robin arbiter sharing one I2C master among N_REQ requesters,
//            with a watchdog that aborts and resets a hung master.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int RST_CYC     = 4,
    parameter int IW          = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [7*N_REQ-1:0] req_slave_addr,
    input  logic [7*N_REQ-1:0] req_reg_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_timeout,
    output logic [IW-1:0]      grant_idx,
    output logic               ctrl_busy,
    output logic               m_start,
    output logic               m_read_write,
    output logic [6:0]         m_slave_addr,
    output logic [6:0]         m_reg_addr,
    output logic [7:0]         m_data_in,
    input  logic [7:0]         m_data_out,
    input  logic               m_busy,
    input  logic               m_done,
    output logic               m_rst
);

    localparam int c_WDW = $clog2(TIMEOUT_CYC);
    localparam int c_RCW = $clog2(RST_CYC + 1);
    // r_wd reads 0 in the first WAIT cycle, so the abort response lands
    // exactly TIMEOUT_CYC cycles after the m_start cycle.
    localparam logic [c_WDW-1:0] c_WD_LAST  = c_WDW'(TIMEOUT_CYC - 2);
    localparam logic [c_RCW-1:0] c_RST_LAST = c_RCW'(RST_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_grant_idx;
    logic [c_WDW-1:0]  r_wd;
    logic [c_RCW-1:0]  r_rst_cnt;
    logic              r_m_rw;
    logic [6:0]        r_m_slave_addr;
    logic [6:0]        r_m_reg_addr;
    logic [7:0]        r_m_data_in;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [7:0]        r_rsp_rdata;
    logic              r_rsp_timeout;

    logic [IW:0]       w_cand;
    logic [IW:0]       w_ptr_inc;
    logic [IW-1:0]     w_sel_idx;
    logic              w_sel_found;
    logic              w_accept;
    logic              w_launch;
    logic              w_done_hit;
    logic              w_wd_expire;

    // First valid requester at or above the pointer, wrapping once.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N_REQ)) begin
                w_cand = w_cand - (IW+1)'(N_REQ);
            end
            if (!w_sel_found && req_valid[w_cand[IW-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_inc = {1'b0, w_sel_idx} + 1'b1;
        if (w_ptr_inc >= (IW+1)'(N_REQ)) begin
            w_ptr_inc = '0;
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_sel_found;
    assign req_ready = (w_accept && !rst) ? (N_REQ'(1) << w_sel_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done_hit  = 1'b0;
        w_wd_expire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!m_busy) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wd == c_WD_LAST) begin
                    w_wd_expire = 1'b1;
                    w_state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr          <= '0;
            r_grant_idx    <= '0;
            r_wd           <= '0;
            r_rst_cnt      <= '0;
            r_m_rw         <= 1'b0;
            r_m_slave_addr <= '0;
            r_m_reg_addr   <= '0;
            r_m_data_in    <= '0;
            r_rsp_valid    <= '0;
            r_rsp_rdata    <= '0;
            r_rsp_timeout  <= 1'b0;
        end else begin
            r_rsp_valid   <= '0;
            r_rsp_timeout <= 1'b0;
            if (w_accept) begin
                r_m_rw         <= req_rw[w_sel_idx];
                r_m_slave_addr <= req_slave_addr[7*w_sel_idx +: 7];
                r_m_reg_addr   <= req_reg_addr[7*w_sel_idx +: 7];
                r_m_data_in    <= req_wdata[8*w_sel_idx +: 8];
                r_grant_idx    <= w_sel_idx;
                r_ptr          <= w_ptr_inc[IW-1:0];
            end
            if (w_launch) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_done_hit) begin
                r_rsp_valid <= N_REQ'(1) << r_grant_idx;
                r_rsp_rdata <= r_m_rw ? m_data_out : 8'h00;
            end
            if (w_wd_expire) begin
                r_rsp_valid   <= N_REQ'(1) << r_grant_idx;
                r_rsp_timeout <= 1'b1;
                r_rsp_rdata   <= 8'h00;
                r_rst_cnt     <= '0;
            end else if (r_state == S_RECOVER) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    assign m_start      = w_launch;
    assign m_rst        = (r_state == S_RECOVER);
    assign ctrl_busy    = (r_state != S_IDLE);
    assign m_read_write = r_m_rw;
    assign m_slave_addr = r_m_slave_addr;
    assign m_reg_addr   = r_m_reg_addr;
    assign m_data_in    = r_m_data_in;
    assign grant_idx    = r_grant_idx;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_timeout  = r_rsp_timeout;

endmodule
`default_nettype wire
